// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM-stage data-memory access controller.
// Access-size decode helpers used by the controller and load aligner.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] STRB_NONE = 4'b0000;
    localparam logic [3:0] STRB_B    = 4'b0001;
    localparam logic [3:0] STRB_HLO  = 4'b0011;
    localparam logic [3:0] STRB_HHI  = 4'b1100;
    localparam logic [3:0] STRB_W    = 4'b1111;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } state_e;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W
    } size_e;

    // Reserved encodings fall through to a full-word access.
    function automatic size_e size_of(input logic [2:0] f3);
        size_e sz;
        case (f3)
            F3_B, F3_BU: sz = SZ_B;
            F3_H, F3_HU: sz = SZ_H;
            default:     sz = SZ_W;
        endcase
        return sz;
    endfunction

    // Byte offset truncated to the natural alignment of the access size.
    function automatic logic [1:0] eff_off(input size_e sz,
                                           input logic [1:0] a);
        logic [1:0] o;
        case (sz)
            SZ_B:    o = a;
            SZ_H:    o = {a[1], 1'b0};
            default: o = 2'b00;
        endcase
        return o;
    endfunction

    function automatic logic misaligned(input size_e sz,
                                        input logic [1:0] a);
        logic m;
        case (sz)
            SZ_B:    m = 1'b0;
            SZ_H:    m = a[0];
            default: m = (a != 2'b00);
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_load_align.sv
// Load data aligner: picks the addressed lane of the bus word and
// sign- or zero-extends it according to the load size.
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  fun3_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select followed by extension.
    always_comb begin
        byte_sel = rdata_i[8*off_i +: 8];
        half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (fun3_i)
            F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   data_o = {24'h0, byte_sel};
            F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
            F3_HU:   data_o = {16'h0, half_sel};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: valid/ready bus sequencing,
// byte strobes, load alignment, timeout abort. Option: MISALIGN_TRAP_EN.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W = (TIMEOUT_CYCLES > 0) ?
                          $clog2(TIMEOUT_CYCLES + 1) : 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] write_data_in,
    input  logic [2:0]  fun3_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    output logic        stall_out,
    output logic [31:0] read_data_out,
    output logic        read_valid_out,
    output logic        err_out,
    output logic        misalign_out,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata
);

    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TO_LAST =
        CNT_W'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);

    state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [1:0]  off_q, off_d;
    logic [2:0]  fun3_q, fun3_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rv_q, rv_d;
    logic        err_q, err_d;
    logic        mis_q, mis_d;

    logic        access;
    logic        stall;
    logic        mis_in;
    logic        to_hit;
    size_e       sz_in;
    logic [1:0]  off_in;
    logic [3:0]  strb_st;
    logic [31:0] wd_st;
    logic [31:0] ld_data;

    assign access = valid_in & (mem_read_in | mem_write_in);
    assign sz_in  = size_of(fun3_in);
    assign off_in = eff_off(sz_in, alu_result_in[1:0]);
    assign to_hit = TO_EN && (cnt_q == TO_LAST);

`ifdef MISALIGN_TRAP_EN
    assign mis_in = misaligned(sz_in, alu_result_in[1:0]);
`else
    assign mis_in = 1'b0;
`endif

    // Store lane replication and byte-enable generation.
    always_comb begin
        case (sz_in)
            SZ_B: begin
                strb_st = STRB_B << off_in;
                wd_st   = {4{write_data_in[7:0]}};
            end
            SZ_H: begin
                strb_st = off_in[1] ? STRB_HHI : STRB_HLO;
                wd_st   = {2{write_data_in[15:0]}};
            end
            default: begin
                strb_st = STRB_W;
                wd_st   = write_data_in;
            end
        endcase
    end

    load_align u_load_align (
        .rdata_i (bus_rdata),
        .off_i   (off_q),
        .fun3_i  (fun3_q),
        .data_o  (ld_data)
    );

    // Next-state, latched bus fields and completion pulses.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        off_d   = off_q;
        fun3_d  = fun3_q;
        rdata_d = rdata_q;
        rv_d    = 1'b0;
        err_d   = 1'b0;
        mis_d   = 1'b0;
        stall   = 1'b0;
        unique case (state_q)
            IDLE: begin
                stall = access;
                if (access) begin
                    we_d    = mem_write_in;
                    addr_d  = {alu_result_in[31:2], 2'b00};
                    wdata_d = wd_st;
                    wstrb_d = mem_write_in ? strb_st : STRB_NONE;
                    off_d   = off_in;
                    fun3_d  = fun3_in;
                    cnt_d   = '0;
                    if (mis_in) begin
                        mis_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                stall = 1'b1;
                if (bus_ready) begin
                    state_d = DONE;
                    if (!we_q) begin
                        rv_d    = 1'b1;
                        rdata_d = ld_data;
                    end
                end else if (to_hit) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            off_q   <= '0;
            fun3_q  <= '0;
            rdata_q <= '0;
            rv_q    <= 1'b0;
            err_q   <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            off_q   <= off_d;
            fun3_q  <= fun3_d;
            rdata_q <= rdata_d;
            rv_q    <= rv_d;
            err_q   <= err_d;
            mis_q   <= mis_d;
        end
    end

    assign stall_out      = stall & ~reset;
    assign bus_req        = (state_q == REQ);
    assign bus_we         = we_q;
    assign bus_addr       = addr_q;
    assign bus_wdata      = wdata_q;
    assign bus_wstrb      = wstrb_q;
    assign read_data_out  = rdata_q;
    assign read_valid_out = rv_q;
    assign err_out        = err_q;
    assign misalign_out   = mis_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: vector table plus reset and
// back-to-back sequences. Expects TIMEOUT_CYCLES = 4.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid_in = 1'b0;
    logic [31:0] alu_result_in = '0;
    logic [31:0] write_data_in = '0;
    logic [2:0]  fun3_in = '0;
    logic        mem_read_in = 1'b0;
    logic        mem_write_in = 1'b0;
    logic        stall_out;
    logic [31:0] read_data_out;
    logic        read_valid_out;
    logic        err_out;
    logic        misalign_out;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_ready = 1'b0;
    logic [31:0] bus_rdata = '0;

    int total = 0;
    int bad = 0;
    int xfers = 0;

    mem_access_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .valid_in       (valid_in),
        .alu_result_in  (alu_result_in),
        .write_data_in  (write_data_in),
        .fun3_in        (fun3_in),
        .mem_read_in    (mem_read_in),
        .mem_write_in   (mem_write_in),
        .stall_out      (stall_out),
        .read_data_out  (read_data_out),
        .read_valid_out (read_valid_out),
        .err_out        (err_out),
        .misalign_out   (misalign_out),
        .bus_req        (bus_req),
        .bus_we         (bus_we),
        .bus_addr       (bus_addr),
        .bus_wdata      (bus_wdata),
        .bus_wstrb      (bus_wstrb),
        .bus_ready      (bus_ready),
        .bus_rdata      (bus_rdata)
    );

    always #5 clk = ~clk;

    // Transfer monitor: counts accepted bus beats.
    always @(posedge clk) begin
        if (bus_req && bus_ready) xfers <= xfers + 1;
    end

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rdata;
        int          rdy;
        int          nreq;
        logic [31:0] eaddr;
        logic [31:0] ewd;
        logic [3:0]  estrb;
        logic [31:0] erd;
        logic        erv;
        logic        eerr;
        logic        emis;
    } vec_t;

    vec_t tbl[14];

    function automatic vec_t mk(
        input logic rd, input logic wr, input logic [2:0] f3,
        input logic [31:0] addr, input logic [31:0] wd,
        input logic [31:0] rdata, input int rdy, input int nreq,
        input logic [31:0] eaddr, input logic [31:0] ewd,
        input logic [3:0] estrb, input logic [31:0] erd,
        input logic erv, input logic eerr, input logic emis);
        vec_t v;
        v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr;
        v.wd = wd; v.rdata = rdata; v.rdy = rdy; v.nreq = nreq;
        v.eaddr = eaddr; v.ewd = ewd; v.estrb = estrb;
        v.erd = erd; v.erv = erv; v.eerr = eerr; v.emis = emis;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic run_txn(input string tag, input vec_t v);
        int  stalls;
        int  nreq;
        bit  done;
        stalls = 0;
        nreq = 0;
        done = 0;
        @(negedge clk);
        valid_in = 1'b1;
        mem_read_in = v.rd;
        mem_write_in = v.wr;
        fun3_in = v.f3;
        alu_result_in = v.addr;
        write_data_in = v.wd;
        bus_ready = 1'b0;
        bus_rdata = v.rdata;
        #1;
        if (stall_out) stalls++;
        chk({tag, "_idle_stall"}, 32'(stall_out), 32'd1);
        @(posedge clk);
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (stall_out !== 1'b1) begin
                done = 1;
            end else begin
                stalls++;
                nreq++;
                chk({tag, "_req"}, 32'(bus_req), 32'd1);
                chk({tag, "_we"}, 32'(bus_we), 32'(v.wr));
                chk({tag, "_addr"}, bus_addr, v.eaddr);
                chk({tag, "_strb"}, 32'(bus_wstrb), 32'(v.estrb));
                if (v.wr) chk({tag, "_wdata"}, bus_wdata, v.ewd);
                bus_ready = (nreq == v.rdy);
            end
        end
        bus_ready = 1'b0;
        if (!done) chk({tag, "_no_done"}, 32'd0, 32'd1);
        chk({tag, "_nreq"}, 32'(nreq), 32'(v.nreq));
        chk({tag, "_stalls"}, 32'(stalls), 32'(v.nreq + 1));
        chk({tag, "_done_req"}, 32'(bus_req), 32'd0);
        chk({tag, "_rv"}, 32'(read_valid_out), 32'(v.erv));
        chk({tag, "_err"}, 32'(err_out), 32'(v.eerr));
        chk({tag, "_mis"}, 32'(misalign_out), 32'(v.emis));
        chk({tag, "_rdata"}, read_data_out, v.erd);
    endtask

    initial begin
        int base;
        tbl[0]  = mk(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 2, 2,
                     32'h100, 32'hDEADBEEF, 4'b1111, 32'h0, 0, 0, 0);
        tbl[1]  = mk(1, 0, 3'b000, 32'h103, 32'h0, 32'h80123456, 1, 1,
                     32'h100, 32'h0, 4'b0000, 32'hFFFFFF80, 1, 0, 0);
        tbl[2]  = mk(1, 0, 3'b100, 32'h103, 32'h0, 32'h80123456, 1, 1,
                     32'h100, 32'h0, 4'b0000, 32'h00000080, 1, 0, 0);
        tbl[3]  = mk(0, 1, 3'b000, 32'h102, 32'h123456AB, 32'h0, 1, 1,
                     32'h100, 32'hABABABAB, 4'b0100, 32'h00000080, 0, 0, 0);
        tbl[4]  = mk(1, 0, 3'b101, 32'h102, 32'h0, 32'hBEEF1234, 1, 1,
                     32'h100, 32'h0, 4'b0000, 32'h0000BEEF, 1, 0, 0);
        tbl[5]  = mk(1, 0, 3'b001, 32'h102, 32'h0, 32'hBEEF1234, 2, 2,
                     32'h100, 32'h0, 4'b0000, 32'hFFFFBEEF, 1, 0, 0);
        tbl[6]  = mk(0, 1, 3'b001, 32'h100, 32'h1234CAFE, 32'h0, 3, 3,
                     32'h100, 32'hCAFECAFE, 4'b0011, 32'hFFFFBEEF, 0, 0, 0);
        tbl[7]  = mk(1, 0, 3'b010, 32'h200, 32'h0, 32'h13579BDF, 1, 1,
                     32'h200, 32'h0, 4'b0000, 32'h13579BDF, 1, 0, 0);
        tbl[8]  = mk(1, 0, 3'b010, 32'h300, 32'h0, 32'h55555555, 0, 4,
                     32'h300, 32'h0, 4'b0000, 32'h0, 0, 1, 0);
        tbl[9]  = mk(1, 0, 3'b011, 32'h204, 32'h0, 32'hA5A55A5A, 1, 1,
                     32'h204, 32'h0, 4'b0000, 32'hA5A55A5A, 1, 0, 0);
        tbl[10] = mk(1, 1, 3'b010, 32'h108, 32'h0BADF00D, 32'h0, 1, 1,
                     32'h108, 32'h0BADF00D, 4'b1111, 32'hA5A55A5A, 0, 0, 0);
        tbl[11] = mk(1, 0, 3'b000, 32'h101, 32'h0, 32'h00007F00, 1, 1,
                     32'h100, 32'h0, 4'b0000, 32'h0000007F, 1, 0, 0);
`ifdef MISALIGN_TRAP_EN
        tbl[12] = mk(1, 0, 3'b010, 32'h101, 32'h0, 32'hCAFEF00D, 1, 0,
                     32'h100, 32'h0, 4'b0000, 32'h0000007F, 0, 0, 1);
        tbl[13] = mk(1, 0, 3'b001, 32'h103, 32'h0, 32'h80010000, 1, 0,
                     32'h100, 32'h0, 4'b0000, 32'h0000007F, 0, 0, 1);
`else
        tbl[12] = mk(1, 0, 3'b010, 32'h101, 32'h0, 32'hCAFEF00D, 1, 1,
                     32'h100, 32'h0, 4'b0000, 32'hCAFEF00D, 1, 0, 0);
        tbl[13] = mk(1, 0, 3'b001, 32'h103, 32'h0, 32'h80010000, 1, 1,
                     32'h100, 32'h0, 4'b0000, 32'hFFFF8001, 1, 0, 0);
`endif

        repeat (2) @(negedge clk);
        chk("rst_req", 32'(bus_req), 32'd0);
        chk("rst_stall", 32'(stall_out), 32'd0);
        chk("rst_rdata", read_data_out, 32'd0);
        chk("rst_pulses",
            32'({read_valid_out, err_out, misalign_out}), 32'd0);
        chk("rst_addr", bus_addr, 32'd0);
        chk("rst_strb", 32'(bus_wstrb), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            run_txn($sformatf("v%0d", i), tbl[i]);
        end

        @(negedge clk);
        mem_read_in = 1'b1;
        mem_write_in = 1'b0;
        fun3_in = 3'b010;
        alu_result_in = 32'h400;
        bus_ready = 1'b0;
        @(negedge clk);
        chk("mid_req_on", 32'(bus_req), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_req", 32'(bus_req), 32'd0);
        chk("mid_rst_stall", 32'(stall_out), 32'd0);
        valid_in = 1'b0;
        mem_read_in = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_rst_pulses",
            32'({read_valid_out, err_out, misalign_out}), 32'd0);
        chk("post_rst_stall", 32'(stall_out), 32'd0);

        base = xfers;
        run_txn("b2b_lw", mk(1, 0, 3'b010, 32'h410, 32'h0, 32'h01020304,
                             1, 1, 32'h410, 32'h0, 4'b0000, 32'h01020304,
                             1, 0, 0));
        run_txn("b2b_sw", mk(0, 1, 3'b010, 32'h414, 32'h99887766,
                             32'h0, 1, 1, 32'h414, 32'h99887766, 4'b1111,
                             32'h01020304, 0, 0, 0));
        valid_in = 1'b0;
        mem_read_in = 1'b0;
        mem_write_in = 1'b0;
        repeat (4) @(negedge clk);
        chk("b2b_xfers", 32'(xfers - base), 32'd2);
        chk("b2b_idle_req", 32'(bus_req), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Sequences the data-memory access for an instruction held in the MEM-stage pipeline register. It translates address, store data, FUN3 and the read/write controls into a valid/ready data-bus transaction with byte strobes. It stalls the pipeline until the bus completes, then returns aligned, sign- or zero-extended load data to the writeback path. A configurable timeout aborts hung transactions.

Parameters:
TIMEOUT_CYCLES, 255, max cycles in REQ without bus_ready before abort; 0 disables timeout.
CNT_W, $clog2(TIMEOUT_CYCLES+1), timeout counter width (derived, do not override).

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
valid_in  in  1  MEM stage holds a real instruction
alu_result_in  in  32  effective byte address
write_data_in  in  32  store source data
fun3_in  in  3  access size/sign (RV32 LB/LH/LW/LBU/LHU, SB/SH/SW)
mem_read_in  in  1  load instruction (ResultSrc selects memory)
mem_write_in  in  1  store instruction
stall_out  out  1  hold pipeline registers upstream of and including MEM
read_data_out  out  32  extended load result
read_valid_out  out  1  one-cycle pulse, read_data_out updated
err_out  out  1  one-cycle pulse, timeout abort
misalign_out  out  1  one-cycle pulse, misaligned access (feature only; else tied 0)
bus_req  out  1  transaction request (valid)
bus_we  out  1  1 = write
bus_addr  out  32  word address, bits [1:0] = 0
bus_wdata  out  32  lane-replicated store data
bus_wstrb  out  4  byte enables (0 for reads)
bus_ready  in  1  transfer accepted this cycle
bus_rdata  in  32  read word, valid when bus_req & bus_ready & !bus_we

Behaviour:
- access = valid_in & (mem_read_in | mem_write_in); both set is treated as write.
- FSM IDLE -> REQ -> DONE -> IDLE. Reset: IDLE, all outputs 0, counter 0.
- IDLE: if access, latch bus fields into registers, go REQ. stall_out = access (combinational).
- REQ: bus_req=1, bus fields stable until transfer. On bus_ready: capture bus_rdata if read, go DONE. If counter reaches TIMEOUT_CYCLES (nonzero) without ready: drop bus_req, go DONE with error. stall_out=1.
- DONE: stall_out=0, pipeline advances at end of this cycle. Read: read_valid_out=1, read_data_out loaded. Timeout: err_out=1, read_data_out=0. Always returns to IDLE, never re-issues.
- Minimum latency: ready in first REQ cycle gives 3 cycles from arrival to advance (IDLE, REQ, DONE).
- read_data_out holds its value between updates.
- Store lanes: SB wdata={4{wd[7:0]}}, wstrb=4'b0001<<addr[1:0]. SH wdata={2{wd[15:0]}}, wstrb=addr[1]?1100:0011. SW full word, 1111.
- Load extract (lane by addr[1:0]): LB/LH sign-extend, LBU/LHU zero-extend, LW pass-through.
- Reserved fun3 (011, 110, 111) is treated as word.
- Reset mid-REQ: bus_req deasserts immediately (async), transaction abandoned, no pulses.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: halfword with addr[0]=1 or word with addr[1:0]!=0 skips REQ, going IDLE->DONE. misalign_out pulses, no bus activity, no read_valid_out.
- Undefined: offset truncated to the access size (halfword uses addr[1], word uses 0) and access performed normally. misalign_out is tied 0.

Decomposition:
- Package mem_pkg: fun3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU), state enum (IDLE/REQ/DONE), strobe constants.
- Sub-module load_align: combinational lane select plus sign/zero extend (rdata, offset, fun3 -> 32b). Instantiated once.

Test Plan:
- SW 0xDEADBEEF @0x100, ready after 2 REQ cycles -> bus_addr 0x100, wstrb 1111, stall high 3 cycles, no read_valid.
- LB @0x103, rdata 0x80123456 -> read_data_out 0xFFFFFF80. LBU same -> 0x00000080. SB 0xAB @0x102 -> wdata 0xABABABAB, wstrb 0100.
- LHU @0x102, rdata 0xBEEF1234 -> 0x0000BEEF. LH same -> 0xFFFFBEEF.
- TIMEOUT_CYCLES=4, bus_ready never -> bus_req drops after 4 REQ cycles, err_out pulse, read_data_out 0, stall released.
- LW @0x101 -> with MISALIGN_TRAP_EN: misalign_out, no bus_req. Without: bus_addr 0x100, full word returned.
- Reset asserted mid-REQ -> bus_req, stall_out 0 immediately. Then back-to-back LW, SW -> exactly two transfers, no duplicate issue.
